// File: rtl/ma_rr_sched.sv
// Slot-timed 4-channel sample scheduler with per-channel 4-sample moving average.
// Define MA_FIXED_PRIO_EN for fixed-priority selection (ch0 highest) instead of round-robin.
module ma_rr_sched #(
    parameter int unsigned c_clkfreq = 100000000,
    parameter int unsigned c_rate    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_i,
    input  logic [31:0] data_i,
    output logic [3:0]  gnt_o,
    output logic        out_valid_o,
    output logic [1:0]  out_ch_o,
    output logic [9:0]  dataout_o
);

    localparam int unsigned P  = c_clkfreq / c_rate;
    localparam int unsigned CW = $clog2(P + 1);
    localparam logic [CW-1:0] PCnt = CW'(P);
    localparam logic [CW-1:0] OneCnt = CW'(1);

    typedef enum logic [1:0] {StIdle, StGrant, StCalc, StOut} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic [1:0]    sel_ch;
    logic [1:0]    sel_q;
    logic [7:0]    sample_q;
    logic [7:0]    h0_q [4];
    logic [7:0]    h1_q [4];
    logic [7:0]    h2_q [4];
    logic [9:0]    sum;
    logic [1:0]    out_ch_q;
    logic [9:0]    dataout_q;
    logic          do_grant;

    assign tick     = (cnt_q == PCnt);
    assign cnt_d    = tick ? OneCnt : cnt_q + OneCnt;
    assign do_grant = (state_q == StIdle) && tick && (req_i != 4'b0000);

`ifdef MA_FIXED_PRIO_EN
    always_comb begin
        sel_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_i[i]) sel_ch = 2'(i);
        end
    end
`else
    logic [1:0] last_q;
    logic [1:0] idx;

    // Descending scan so the smallest offset from last_q + 1 wins.
    always_comb begin
        sel_ch = 2'd0;
        idx    = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            idx = last_q + 2'(i);
            if (req_i[idx]) sel_ch = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 2'd3;
        end else if (do_grant) begin
            last_q <= sel_ch;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        gnt_o       = 4'b0000;
        out_valid_o = 1'b0;
        unique case (state_q)
            StIdle:  if (do_grant) state_d = StGrant;
            StGrant: begin
                gnt_o   = 4'b0001 << sel_q;
                state_d = StCalc;
            end
            StCalc:  state_d = StOut;
            StOut: begin
                out_valid_o = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign sum = {2'b00, h2_q[sel_q]} + {2'b00, h1_q[sel_q]} + {2'b00, h0_q[sel_q]}
               + {2'b00, sample_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= OneCnt;
            sel_q     <= 2'd0;
            sample_q  <= 8'd0;
            out_ch_q  <= 2'd0;
            dataout_q <= 10'd0;
            for (int k = 0; k < 4; k++) begin
                h0_q[k] <= 8'd0;
                h1_q[k] <= 8'd0;
                h2_q[k] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_grant) sel_q <= sel_ch;
            // Sample is taken in GRANT whether or not the requester still holds req_i.
            if (state_q == StGrant) sample_q <= data_i[8*sel_q +: 8];
            if (state_q == StCalc) begin
                h2_q[sel_q] <= h1_q[sel_q];
                h1_q[sel_q] <= h0_q[sel_q];
                h0_q[sel_q] <= sample_q;
                out_ch_q    <= sel_q;
                dataout_q   <= {2'b00, sum[9:2]};
            end
        end
    end

    assign out_ch_o  = out_ch_q;
    assign dataout_o = dataout_q;

endmodule

// File: tb/tb_ma_rr_sched.sv
// Directed self-checking bench for ma_rr_sched with P = 4 (40 Hz clock, 10 slots/s).
// Expectations follow MA_FIXED_PRIO_EN when the bench is built with that macro.
module tb_ma_rr_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  gnt_o;
    logic        out_valid_o;
    logic [1:0]  out_ch_o;
    logic [9:0]  dataout_o;

    int n_checks = 0;
    int n_fails  = 0;

    ma_rr_sched #(
        .c_clkfreq(40),
        .c_rate   (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .data_i     (data_i),
        .gnt_o      (gnt_o),
        .out_valid_o(out_valid_o),
        .out_ch_o   (out_ch_o),
        .dataout_o  (dataout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a request, wait (bounded) for the grant, then follow GRANT -> CALC -> OUT.
    task automatic slot(input logic [3:0] req, input logic [31:0] data, input int exp_wait,
                        input logic [3:0] exp_gnt, input logic [1:0] exp_ch,
                        input logic [9:0] exp_avg, input string tag);
        int waited;
        waited = 0;
        req_i  = req;
        data_i = data;
        do begin
            @(negedge clk);
            waited++;
            if (gnt_o == 4'b0000) check({tag, "_quiet_valid"}, 32'(out_valid_o), 32'd0);
        end while (gnt_o == 4'b0000 && waited < 12);
        check({tag, "_latency"}, 32'(waited), 32'(exp_wait));
        check({tag, "_gnt"}, 32'(gnt_o), 32'(exp_gnt));
        check({tag, "_gnt_valid"}, 32'(out_valid_o), 32'd0);
        @(negedge clk);
        check({tag, "_calc_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, "_calc_valid"}, 32'(out_valid_o), 32'd0);
        @(negedge clk);
        check({tag, "_out_valid"}, 32'(out_valid_o), 32'd1);
        check({tag, "_out_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, "_out_ch"}, 32'(out_ch_o), 32'(exp_ch));
        check({tag, "_avg"}, 32'(dataout_o), 32'(exp_avg));
    endtask

    initial begin
        int waited;
        rst    = 1'b0;
        req_i  = 4'b0000;
        data_i = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_ch", 32'(out_ch_o), 32'd0);
        check("rst_avg", 32'(dataout_o), 32'd0);

        // All four requesting, every byte 4.
        rst = 1'b1;
`ifdef MA_FIXED_PRIO_EN
        slot(4'b1111, 32'h04040404, 4, 4'b0001, 2'd0, 10'd1, "all1");
        slot(4'b1111, 32'h04040404, 2, 4'b0001, 2'd0, 10'd2, "all2");
        slot(4'b1111, 32'h04040404, 2, 4'b0001, 2'd0, 10'd3, "all3");
        slot(4'b1111, 32'h04040404, 2, 4'b0001, 2'd0, 10'd4, "all4");
        slot(4'b1111, 32'h04040404, 2, 4'b0001, 2'd0, 10'd4, "all5");
`else
        slot(4'b1111, 32'h04040404, 4, 4'b0001, 2'd0, 10'd1, "all1");
        slot(4'b1111, 32'h04040404, 2, 4'b0010, 2'd1, 10'd1, "all2");
        slot(4'b1111, 32'h04040404, 2, 4'b0100, 2'd2, 10'd1, "all3");
        slot(4'b1111, 32'h04040404, 2, 4'b1000, 2'd3, 10'd1, "all4");
        slot(4'b1111, 32'h04040404, 2, 4'b0001, 2'd0, 10'd2, "all5");
`endif

        rst   = 1'b0;
        req_i = 4'b0000;
        @(negedge clk);
        check("rst2_avg", 32'(dataout_o), 32'd0);
        rst = 1'b1;

        // ch1 ramp with sample 100.
        slot(4'b0010, 32'h00006400, 4, 4'b0010, 2'd1, 10'd25, "ch1_a");
        slot(4'b0010, 32'h00006400, 2, 4'b0010, 2'd1, 10'd50, "ch1_b");
        slot(4'b0010, 32'h00006400, 2, 4'b0010, 2'd1, 10'd75, "ch1_c");
        slot(4'b0010, 32'h00006400, 2, 4'b0010, 2'd1, 10'd100, "ch1_d");

        // ch2 full-scale ramp; ch0 history must remain empty.
        slot(4'b0100, 32'h00FF0000, 2, 4'b0100, 2'd2, 10'd63, "ch2_a");
        slot(4'b0100, 32'h00FF0000, 2, 4'b0100, 2'd2, 10'd127, "ch2_b");
        slot(4'b0100, 32'h00FF0000, 2, 4'b0100, 2'd2, 10'd191, "ch2_c");
        slot(4'b0100, 32'h00FF0000, 2, 4'b0100, 2'd2, 10'd255, "ch2_d");
        slot(4'b0001, 32'h00FF0008, 2, 4'b0001, 2'd0, 10'd2, "ch0_iso");

        // Three empty ticks: no activity, outputs hold.
        req_i = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("idle_gnt", 32'(gnt_o), 32'd0);
            check("idle_valid", 32'(out_valid_o), 32'd0);
            check("idle_hold_avg", 32'(dataout_o), 32'd2);
            check("idle_hold_ch", 32'(out_ch_o), 32'd0);
        end
        slot(4'b1000, 32'h28000000, 2, 4'b1000, 2'd3, 10'd10, "ch3_a");
        slot(4'b1000, 32'h28000000, 2, 4'b1000, 2'd3, 10'd20, "ch3_b");
        slot(4'b1000, 32'h28000000, 2, 4'b1000, 2'd3, 10'd30, "ch3_c");

        // ch3 history is {40,40,40}; abort the next operation in CALC.
        req_i  = 4'b1000;
        data_i = 32'h28000000;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt_o == 4'b0000 && waited < 12);
        check("abort_latency", 32'(waited), 32'd2);
        check("abort_gnt", 32'(gnt_o), 32'b1000);
        @(negedge clk);
        check("abort_calc_valid", 32'(out_valid_o), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_rst_valid", 32'(out_valid_o), 32'd0);
        check("abort_rst_gnt", 32'(gnt_o), 32'd0);
        check("abort_rst_avg", 32'(dataout_o), 32'd0);
        check("abort_rst_ch", 32'(out_ch_o), 32'd0);
        @(negedge clk);
        check("abort_hold_valid", 32'(out_valid_o), 32'd0);
        rst = 1'b1;
        slot(4'b1000, 32'hC8000000, 4, 4'b1000, 2'd3, 10'd50, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
